// File: rtl/mult_job_sequencer_if.sv
// rtl/mult_job_sequencer_if.sv - operand stream, multiplier handshake and result stream of the job sequencer
interface mult_job_sequencer_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;

  logic            mult_start;
  logic [N-1:0]    ABus;
  logic [N-1:0]    BBus;
  logic            mult_ready;
  logic [2*N-1:0]  resultBus;

  logic            out_valid;
  logic            out_ready;
  logic [2*N-1:0]  out_result;
  logic [N-1:0]    out_a;
  logic [N-1:0]    out_b;
  logic [CW-1:0]   out_cycles;

  logic [CNTW-1:0] fifo_count;
  logic            busy;

  // The sequencer is the slave side; producer, multiplier and consumer form the master side.
  modport slave (
    input  in_valid, in_a, in_b, mult_ready, resultBus, out_ready,
    output in_ready, mult_start, ABus, BBus, out_valid, out_result, out_a, out_b,
           out_cycles, fifo_count, busy
  );

  modport master (
    output in_valid, in_a, in_b, mult_ready, resultBus, out_ready,
    input  in_ready, mult_start, ABus, BBus, out_valid, out_result, out_a, out_b,
           out_cycles, fifo_count, busy
  );
endinterface

// File: rtl/mult_job_sequencer.sv
// rtl/mult_job_sequencer.sv - operand FIFO and one-job-at-a-time sequencer for the add-and-shift multiplier
module mult_job_sequencer #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_job_sequencer_if.slave bus
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_LOW  = 3'd2;
  localparam logic [2:0] S_WAIT_HIGH = 3'd3;
  localparam logic [2:0] S_OUT       = 3'd4;

  logic [N-1:0]   fifo_a [DEPTH];
  logic [N-1:0]   fifo_b [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           in_ready_i;
  logic           push;
  logic           pop;

  logic [2:0]     state;
  logic [N-1:0]   a_reg;
  logic [N-1:0]   b_reg;
  logic [CW-1:0]  cyc_cnt;
  logic [CW-1:0]  cyc_next;
  logic [1:0]     miss_cnt;

  logic           out_valid_q;
  logic [2*N-1:0] out_result_q;
  logic [N-1:0]   out_a_q;
  logic [N-1:0]   out_b_q;
  logic [CW-1:0]  out_cycles_q;

  assign in_ready_i = (count != FULL_COUNT);
  assign push       = bus.in_valid && in_ready_i;
  assign pop        = (state == S_IDLE) && (count != '0) && bus.mult_ready;
  assign cyc_next   = (cyc_cnt == {CW{1'b1}}) ? cyc_cnt : cyc_cnt + CW'(1);

  // Storage needs no reset: an entry is only read after count says it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_a;
      fifo_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The cycle counter runs from the start cycle through the capture cycle inclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      cyc_cnt      <= '0;
      miss_cnt     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_cycles_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            a_reg <= fifo_a[rd_ptr];
            b_reg <= fifo_b[rd_ptr];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cyc_cnt  <= CW'(1);
          miss_cnt <= '0;
          state    <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          cyc_cnt <= cyc_next;
          if (!bus.mult_ready) begin
            state <= S_WAIT_HIGH;
          end else if (miss_cnt == 2'd3) begin
            // Multiplier never left ready: the start was lost, pulse it again.
            state <= S_ISSUE;
          end else begin
            miss_cnt <= miss_cnt + 2'd1;
          end
        end
        S_WAIT_HIGH: begin
          cyc_cnt <= cyc_next;
          if (bus.mult_ready) begin
            out_result_q <= bus.resultBus;
            out_a_q      <= a_reg;
            out_b_q      <= b_reg;
            out_cycles_q <= cyc_next;
            out_valid_q  <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_i;
  assign bus.mult_start = (state == S_ISSUE);
  assign bus.ABus       = a_reg;
  assign bus.BBus       = b_reg;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_a      = out_a_q;
  assign bus.out_b      = out_b_q;
  assign bus.out_cycles = out_cycles_q;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb/tb_mult_job_sequencer.sv - scoreboard bench for mult_job_sequencer with a behavioural multiplier
module tb_mult_job_sequencer;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } job_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_job_sequencer_if #(.N(N), .DEPTH(DEPTH), .CW(CW)) bus ();

  mult_job_sequencer #(.N(N), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           mdl_ready  = 1'b1;
  logic           hold_low   = 1'b0;
  logic [2*N-1:0] mdl_result = '0;
  assign bus.mult_ready = mdl_ready & ~hold_low;
  assign bus.resultBus  = mdl_result;

  int  mdl_d       = 5;
  bit  rand_d      = 1'b0;
  bit  ignore_next = 1'b0;
  bit  rand_out    = 1'b0;

  job_t sb_q[$];
  int   cyc_q[$];
  int   start_hist[$];
  int   start_a[$];
  int   nstarts     = 0;
  int   njobs       = 0;
  int   peak        = 0;
  int   last_hs     = -1;
  int   last_cycles = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier: drops ready the cycle after a start, stays busy D cycles, then shows the product.
  initial begin
    logic         s;
    logic [N-1:0] sa, sbv;
    int           sc, st, rem, d;
    bit           running;
    logic [2*N-1:0] prod;
    running = 0; st = 0; rem = 0; prod = '0;
    forever begin
      @(negedge clk);
      s = bus.mult_start; sa = bus.ABus; sbv = bus.BBus; sc = cyc;
      @(posedge clk); #1;
      if (!rst_n) begin
        mdl_ready = 1'b1; running = 0; ignore_next = 1'b0;
      end else if (running) begin
        if (rem == 0) begin
          mdl_ready  = 1'b1;
          mdl_result = prod;
          running    = 0;
          cyc_q.push_back(cyc - st + 1);
        end else begin
          rem--;
        end
      end else if (s) begin
        if (ignore_next) begin
          ignore_next = 1'b0;
        end else begin
          d          = rand_d ? int'($urandom_range(1, 6)) : mdl_d;
          running    = 1;
          mdl_ready  = 1'b0;
          mdl_result = (2*N)'($urandom);
          prod       = (2*N)'(int'(sa) * int'(sbv));
          st         = sc;
          rem        = d - 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_out) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor and scoreboard.
  initial begin
    bit             prev_hold;
    logic [2*N-1:0] h_res;
    logic [N-1:0]   h_a, h_b;
    logic [CW-1:0]  h_cyc;
    job_t           e;
    prev_hold = 0; h_res = '0; h_a = '0; h_b = '0; h_cyc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete(); cyc_q.delete(); prev_hold = 0;
        continue;
      end
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
      if (int'(bus.fifo_count) == DEPTH) check("in_ready_when_full", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) sb_q.push_back('{bus.in_a, bus.in_b});
      if (bus.mult_start) begin
        nstarts++;
        start_hist.push_back(cyc);
        start_a.push_back(int'(bus.ABus));
        check("start_after_handshake", (cyc > last_hs) ? 1 : 0, 1);
        if (sb_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_start: ABus %0d BBus %0d with no pending job", bus.ABus, bus.BBus);
        end else begin
          check("start_ABus", bus.ABus, sb_q[0].a);
          check("start_BBus", bus.BBus, sb_q[0].b);
        end
      end
      if (prev_hold) begin
        check("held_out_valid", bus.out_valid, 1);
        check("held_out_result", bus.out_result, h_res);
        check("held_out_a", bus.out_a, h_a);
        check("held_out_b", bus.out_b, h_b);
        check("held_out_cycles", bus.out_cycles, h_cyc);
      end
      prev_hold = 0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          last_hs     = cyc;
          last_cycles = int'(bus.out_cycles);
          njobs++;
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: result %0d with no pending job", bus.out_result);
          end else begin
            e = sb_q.pop_front();
            check("out_result", bus.out_result, int'(e.a) * int'(e.b));
            check("out_a", bus.out_a, e.a);
            check("out_b", bus.out_b, e.b);
          end
          if (cyc_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL out_cycles: got %0d, multiplier never completed", bus.out_cycles);
          end else begin
            check("out_cycles", bus.out_cycles, cyc_q.pop_front());
          end
        end else begin
          prev_hold = 1;
          h_res = bus.out_result; h_a = bus.out_a; h_b = bus.out_b; h_cyc = bus.out_cycles;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    do begin @(negedge clk); t++; end while (!bus.in_ready && t < 300);
    check("push_accepted", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int target);
    int t;
    t = 0;
    while (njobs < target && t < 3000) begin tick(1); t++; end
    check("jobs_completed", njobs, target);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_fifo_count"}, bus.fifo_count, 0);
    check({tag, "_mult_start"}, bus.mult_start, 0);
    check({tag, "_ABus"}, bus.ABus, 0);
    check({tag, "_BBus"}, bus.BBus, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_result"}, bus.out_result, 0);
    check({tag, "_out_a"}, bus.out_a, 0);
    check({tag, "_out_b"}, bus.out_b, 0);
    check({tag, "_out_cycles"}, bus.out_cycles, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int base, jb, s0, t;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_reset("reset");
    rst_n = 1'b1;
    tick(2);

    // Single job, 5-cycle multiply.
    base = nstarts; mdl_d = 5;
    push_pair(4'd3, 4'd5);
    wait_jobs(1);
    check("single_start_count", nstarts - base, 1);
    check("single_out_cycles", last_cycles, 7);
    tick(2);
    check("single_busy_idle", bus.busy, 0);

    // Fill the FIFO while the multiplier is held busy, then drain.
    hold_low = 1'b1; mdl_d = 3; peak = 0; base = nstarts; jb = njobs;
    push_pair(4'd15, 4'd15);
    push_pair(4'd0, 4'd9);
    push_pair(4'd1, 4'd1);
    push_pair(4'd7, 4'd8);
    check("full_fifo_count", bus.fifo_count, 4);
    check("full_in_ready", bus.in_ready, 0);
    hold_low = 1'b0;
    wait_jobs(jb + 4);
    check("full_peak", peak, 4);
    check("full_start_count", nstarts - base, 4);

    // Consumer stalls for 10 cycles on the first result.
    bus.out_ready = 1'b0; jb = njobs; mdl_d = 2;
    push_pair(4'd2, 4'd7);
    push_pair(4'd5, 4'd3);
    t = 0;
    while (!bus.out_valid && t < 200) begin @(negedge clk); t++; end
    check("stall_out_valid_seen", bus.out_valid, 1);
    base = nstarts;
    tick(10);
    check("stall_no_new_start", nstarts - base, 0);
    check("stall_valid_held", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    wait_jobs(jb + 2);

    // Multiplier misses the first start pulse.
    ignore_next = 1'b1; mdl_d = 2; jb = njobs; s0 = start_hist.size();
    push_pair(4'd6, 4'd7);
    wait_jobs(jb + 1);
    check("repulse_start_count", start_hist.size() - s0, 2);
    if (start_hist.size() - s0 == 2) begin
      check("repulse_gap", start_hist[s0+1] - start_hist[s0], 5);
      check("repulse_first_ABus", start_a[s0], 6);
      check("repulse_second_ABus", start_a[s0+1], 6);
    end

    // Push lands on the same cycle as the pop that empties the FIFO.
    hold_low = 1'b1; jb = njobs; mdl_d = 4;
    push_pair(4'd2, 4'd3);
    check("pushpop_pre_count", bus.fifo_count, 1);
    hold_low = 1'b0;
    bus.in_valid = 1'b1; bus.in_a = 4'd4; bus.in_b = 4'd4;
    @(negedge clk);
    check("pushpop_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pushpop_count_held", bus.fifo_count, 1);
    check("pushpop_busy", bus.busy, 1);
    wait_jobs(jb + 2);

    // Reset in the middle of a job with two pairs still queued.
    hold_low = 1'b1; mdl_d = 6; jb = njobs;
    push_pair(4'd9, 4'd9);
    push_pair(4'd10, 4'd2);
    push_pair(4'd11, 4'd3);
    hold_low = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (bus.mult_ready && t < 100);
    check("abort_multiplier_busy", bus.mult_ready, 0);
    tick(2);
    check("abort_queued", bus.fifo_count, 2);
    check("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("abort_no_result", njobs - jb, 0);
    check("abort_fifo_empty", bus.fifo_count, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_idle", bus.busy, 0);

    // Randomized traffic with random multiply latency and consumer backpressure.
    rand_d = 1'b1; rand_out = 1'b1; jb = njobs;
    for (int i = 0; i < 30; i++) begin
      push_pair(N'($urandom), N'($urandom));
      tick($urandom_range(0, 2));
    end
    rand_out = 1'b0;
    bus.out_ready = 1'b1;
    wait_jobs(jb + 30);
    tick(3);
    check("final_fifo_empty", bus.fifo_count, 0);
    check("final_idle", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
- Operand-side and result-side sequencer for the 4-bit add-and-shift multiplier (start/ready handshake, ABus/BBus operands, 8-bit resultBus).
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one multiply at a time, holds operands stable for the whole job, and captures the product when the multiplier returns to ready.
- Presents the product, its operands and a cycle count on a valid/ready output stream.

Parameters:
- N, 4, operand width; product width is 2N.
- DEPTH, 4, operand FIFO entries (power of two, >=2).
- CW, 8, width of per-job cycle counter (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept.
- in_a  in  N  multiplicand.
- in_b  in  N  multiplier.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- ABus  out  N  operand A to the multiplier.
- BBus  out  N  operand B to the multiplier.
- mult_ready  in  1  multiplier ready/idle.
- resultBus  in  2N  multiplier product.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  2N  captured product.
- out_a  out  N  operand A of this job.
- out_b  out  N  operand B of this job.
- out_cycles  out  CW  cycles from mult_start to capture, saturating.
- fifo_count  out  log2(DEPTH)+1  entries buffered.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_count=0, in_ready=1, FSM=IDLE, mult_start=0, ABus=BBus=0, out_valid=0, out_result/out_a/out_b/out_cycles=0, busy=0.
- FIFO:
  - Push when in_valid && in_ready; in_ready = (fifo_count != DEPTH).
  - Pop only in IDLE, under the condition below.
  - Push and pop in the same cycle is allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - A pair pushed at cycle t is poppable no earlier than t+1.
- FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, OUT.
  - IDLE: if fifo_count!=0 && mult_ready, pop head into ABus/BBus registers → ISSUE; else stay.
  - ISSUE: mult_start=1 for exactly this cycle; cycle counter cleared to 1 → WAIT_LOW.
  - WAIT_LOW: wait for mult_ready==0 → WAIT_HIGH.
    - If mult_ready stays 1 for 4 consecutive cycles in WAIT_LOW, the start was missed: return to ISSUE and re-pulse with the same operands.
  - WAIT_HIGH: counter increments each cycle, saturating at 2^CW-1. On mult_ready==1: resultBus→out_result, ABus→out_a, BBus→out_b, counter→out_cycles; out_valid=1 → OUT.
  - OUT: hold all out_* stable while out_valid && !out_ready. On out_ready, out_valid=0 next cycle → IDLE. The next job issues no earlier than the cycle after the handshake.
- ABus/BBus change only on a pop; they hold from ISSUE through capture and beyond.
- mult_start is never asserted outside ISSUE.
- Jobs complete strictly in FIFO order; no job is dropped or duplicated (the re-pulse repeats a start, not a job).
- Product is taken from the multiplier unmodified; no arithmetic is performed on it.
- Reset mid-job aborts immediately:
  - All buffered pairs are discarded.
  - mult_start deasserts asynchronously.
  - No result is emitted for the aborted job.
- busy=1 in all states except IDLE.

Test Plan:
- Reset, push (3,5), multiplier model answering ready low 1 cycle after start and high 5 cycles later → exactly one mult_start pulse; out_valid with out_result=15, out_a=3, out_b=5, out_cycles=7; busy returns to 0.
- Push (15,15),(0,9),(1,1),(7,8) back-to-back with out_ready=1 → fifo_count peaks at 4, in_ready=0 while full, outputs 225,0,1,56 in order, one start per job.
- Hold out_ready=0 for 10 cycles after the first result → out_valid and out_* stable; no second mult_start until the cycle after out_ready=1.
- Multiplier ignores first start (ready stays 1) → second mult_start 5 cycles after the first, same ABus/BBus, single result emitted.
- Push on the cycle fifo_count goes 1→0 from a pop → count stays 1; entry issued next IDLE.
- Assert rst_n=0 during WAIT_HIGH with 2 pairs queued → all outputs reset values; no out_valid after release; fifo_count=0.
